tx_packet_assembler: RTL

Parametrised, clocked successor to the switch/key-driven TX input stage. It assembles a header plus an N-byte payload packet from operator key presses. The packet is then offered to the downstream CRC/serialiser through a valid/ready handshake. It adds a synchronised press detector, explicit length checking, sequence/overflow error flags and a completed-packet counter.

---
 rtl/tx_packet_assembler_if.sv | 37 +++
 rtl/tx_packet_assembler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tx_packet_assembler_if.sv
// Bundle of key-stage inputs and packet-side outputs for the TX packet assembler.
// The slave modport is the assembler side; the master modport is the operator/downstream side.
interface tx_packet_assembler_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 16,
  parameter int ID_W      = 2,
  parameter int LEN_W     = 4,
  parameter int CNT_W     = 8
) ();
  localparam int PKT_W = 2*ID_W + LEN_W + MAX_BYTES*DATA_W;
  localparam int BC_W  = $clog2(MAX_BYTES+1);

  logic              load_n;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data;
  logic              pkt_ready;
  logic [PKT_W-1:0]  tx_packet;
  logic              pkt_valid;
  logic              header_done;
  logic              data_done;
  logic              test_mode;
  logic [BC_W-1:0]   byte_count;
  logic [1:0]        err;
  logic [CNT_W-1:0]  pkt_count;

  modport slave (
    input  load_n, mode, data, pkt_ready,
    output tx_packet, pkt_valid, header_done, data_done, test_mode,
           byte_count, err, pkt_count
  );

  modport master (
    output load_n, mode, data, pkt_ready,
    input  tx_packet, pkt_valid, header_done, data_done, test_mode,
           byte_count, err, pkt_count
  );
endinterface

// File: rtl/tx_packet_assembler.sv
// Builds a header + payload packet from synchronised key presses and offers it
// downstream over valid/ready; tracks sequence/overflow errors and completed packets.
module tx_packet_assembler #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 16,
  parameter int ID_W      = 2,
  parameter int LEN_W     = 4,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  tx_packet_assembler_if.slave bus
);
  // state  | meaning
  // IDLE   | no header for the current packet
  // HDR    | header latched, no payload bytes yet
  // FILL   | 0 < byte_count < target length
  // FULL   | byte_count == target length, ready to send
  // SEND   | packet offered downstream, waiting for pkt_ready
  localparam int HDR_W = 2*ID_W + LEN_W;
  localparam int PAY_W = MAX_BYTES*DATA_W;
  localparam int PKT_W = HDR_W + PAY_W;
  localparam int BC_W  = $clog2(MAX_BYTES+1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FILL, S_FULL, S_SEND} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic [PKT_W-1:0]  tx_packet_q, tx_packet_d;
  logic              header_done_q, header_done_d;
  logic              data_done_q, data_done_d;
  logic              test_mode_q, test_mode_d;
  logic [BC_W-1:0]   byte_count_q, byte_count_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

  logic              press, press_clr, handshake;
  logic [LEN_W-1:0]  len_field;
  logic [BC_W-1:0]   target, byte_inc;

  // sync_q[0..2] are s1..s3; a press is the first cycle s2 sees the key low
  assign sync_d    = {sync_q[1:0], bus.load_n};
  assign press     = sync_q[2] & ~sync_q[1];
  assign press_clr = press && (bus.mode == 2'b00);
  assign handshake = (state_q == S_SEND) && bus.pkt_ready;
  assign len_field = tx_packet_q[PKT_W-2*ID_W-1 -: LEN_W];
  assign byte_inc  = byte_count_q + BC_W'(1);

  always_comb begin
    target = BC_W'(MAX_BYTES);
    if (len_field != '0 && int'(len_field) <= MAX_BYTES)
      target = BC_W'(len_field);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (press_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (press && bus.mode == 2'b01) state_d = S_HDR;
        S_HDR, S_FILL: begin
          if (press && bus.mode == 2'b01) state_d = S_HDR;
          else if (press && bus.mode == 2'b10)
            state_d = (byte_inc == target) ? S_FULL : S_FILL;
        end
        S_FULL: begin
          if (press && bus.mode == 2'b01)      state_d = S_HDR;
          else if (press && bus.mode == 2'b11) state_d = S_SEND;
        end
        S_SEND:  if (handshake) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // handshake is applied first; a clear press then overrides, other presses in SEND drop
  always_comb begin
    tx_packet_d   = tx_packet_q;
    header_done_d = header_done_q;
    data_done_d   = data_done_q;
    test_mode_d   = test_mode_q;
    byte_count_d  = byte_count_q;
    err_d         = err_q;
    pkt_count_d   = pkt_count_q;
    if (handshake) begin
      pkt_count_d   = pkt_count_q + CNT_W'(1);
      header_done_d = 1'b0;
      data_done_d   = 1'b0;
      byte_count_d  = '0;
    end
    if (press_clr) begin
      tx_packet_d   = '0;
      header_done_d = 1'b0;
      data_done_d   = 1'b0;
      test_mode_d   = 1'b0;
      byte_count_d  = '0;
      err_d         = '0;
    end else if (press && state_q != S_SEND) begin
      case (bus.mode)
        2'b01: begin
          tx_packet_d   = {bus.data[HDR_W-1:0], {PAY_W{1'b0}}};
          byte_count_d  = '0;
          header_done_d = 1'b1;
          data_done_d   = 1'b0;
        end
        2'b10: begin
          if (state_q == S_IDLE) begin
            err_d[0] = 1'b1;
          end else if (state_q == S_FULL) begin
            err_d[1] = 1'b1;
          end else begin
            for (int i = 0; i < MAX_BYTES; i++)
              if (byte_count_q == BC_W'(i))
                tx_packet_d[PAY_W-1-i*DATA_W -: DATA_W] = bus.data;
            byte_count_d = byte_inc;
            data_done_d  = (byte_inc == target);
          end
        end
        2'b11: if (state_q != S_FULL) test_mode_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 3'b111;
      tx_packet_q   <= '0;
      header_done_q <= 1'b0;
      data_done_q   <= 1'b0;
      test_mode_q   <= 1'b0;
      byte_count_q  <= '0;
      err_q         <= '0;
      pkt_count_q   <= '0;
    end else begin
      sync_q        <= sync_d;
      tx_packet_q   <= tx_packet_d;
      header_done_q <= header_done_d;
      data_done_q   <= data_done_d;
      test_mode_q   <= test_mode_d;
      byte_count_q  <= byte_count_d;
      err_q         <= err_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  assign bus.tx_packet   = tx_packet_q;
  assign bus.pkt_valid   = (state_q == S_SEND);
  assign bus.header_done = header_done_q;
  assign bus.data_done   = data_done_q;
  assign bus.test_mode   = test_mode_q;
  assign bus.byte_count  = byte_count_q;
  assign bus.err         = err_q;
  assign bus.pkt_count   = pkt_count_q;
endmodule
